// File: rtl/signed_add_arbiter_pkg.sv
// Shared types and constants for the two-requester signed adder arbiter.
package signed_add_arbiter_pkg;

  // Requester identifier: 0 or 1.
  typedef logic req_id_t;

  // last_grant after reset; makes requester 0 win the first contention.
  localparam req_id_t LAST_GRANT_INIT = 1'b1;

endpackage : signed_add_arbiter_pkg

// File: rtl/signed_add_ovf_core.sv
// Combinational W-bit two's-complement adder with signed overflow flag.
module signed_add_ovf_core #(
  parameter int W = 4
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] sum,
  output logic                overflow
);

  // Carry out is dropped. Overflow means both operands have the same sign
  // and the sum has the other sign.
  always_comb begin
    sum      = a + b;
    overflow = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
  end

endmodule : signed_add_ovf_core

// File: rtl/signed_add_arbiter.sv
// Round-robin arbiter sharing one signed adder between two requesters,
// with a one-entry tagged result register and saturating overflow counters.
module signed_add_arbiter
  import signed_add_arbiter_pkg::*;
#(
  parameter int W     = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_vld,
  input  logic [W-1:0]     req0_a,
  input  logic [W-1:0]     req0_b,
  output logic             req0_rdy,
  input  logic             req1_vld,
  input  logic [W-1:0]     req1_a,
  input  logic [W-1:0]     req1_b,
  output logic             req1_rdy,
  output logic             res_vld,
  input  logic             res_rdy,
  output logic [W-1:0]     res_sum,
  output logic             res_overflow,
  output logic             res_id,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] ovf_cnt0,
  output logic [CNT_W-1:0] ovf_cnt1
);

  // Count up by one, sticking at the all-ones value.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic                res_vld_q;
  logic signed [W-1:0] res_sum_q;
  logic                res_ovf_q;
  req_id_t             res_id_q;
  req_id_t             last_grant_q;
  logic [CNT_W-1:0]    ovf_cnt0_q;
  logic [CNT_W-1:0]    ovf_cnt1_q;

  logic                can_accept;
  logic                gnt_vld;
  req_id_t             gnt_id;
  logic                xfer;
  logic signed [W-1:0] op_a;
  logic signed [W-1:0] op_b;
  logic signed [W-1:0] sum_c;
  logic                ovf_c;

  // Grant selection and operand mux; on contention the requester that did
  // not win last time is served.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = 1'b0;
    op_a    = req0_a;
    op_b    = req0_b;
    if (req0_vld && req1_vld) begin
      gnt_vld = 1'b1;
      gnt_id  = ~last_grant_q;
    end else if (req0_vld) begin
      gnt_vld = 1'b1;
      gnt_id  = 1'b0;
    end else if (req1_vld) begin
      gnt_vld = 1'b1;
      gnt_id  = 1'b1;
    end
    if (gnt_id) begin
      op_a = req1_a;
      op_b = req1_b;
    end
  end

  assign can_accept = !res_vld_q || res_rdy;
  assign xfer       = gnt_vld && can_accept;
  assign req0_rdy   = can_accept && gnt_vld && (gnt_id == 1'b0);
  assign req1_rdy   = can_accept && gnt_vld && (gnt_id == 1'b1);

  signed_add_ovf_core #(.W(W)) u_core (
    .a        (op_a),
    .b        (op_b),
    .sum      (sum_c),
    .overflow (ovf_c)
  );

  // Result register: reload on transfer, empty on drain, hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_vld_q    <= 1'b0;
      res_sum_q    <= '0;
      res_ovf_q    <= 1'b0;
      res_id_q     <= 1'b0;
      last_grant_q <= LAST_GRANT_INIT;
    end else if (xfer) begin
      res_vld_q    <= 1'b1;
      res_sum_q    <= sum_c;
      res_ovf_q    <= ovf_c;
      res_id_q     <= gnt_id;
      last_grant_q <= gnt_id;
    end else if (res_rdy) begin
      res_vld_q    <= 1'b0;
    end
  end

  // Per-requester overflow counters; clear wins over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst || clr_cnt) begin
      ovf_cnt0_q <= '0;
      ovf_cnt1_q <= '0;
    end else if (xfer && ovf_c) begin
      if (gnt_id == 1'b0) ovf_cnt0_q <= sat_inc(ovf_cnt0_q);
      else                ovf_cnt1_q <= sat_inc(ovf_cnt1_q);
    end
  end

  assign res_vld      = res_vld_q;
  assign res_sum      = res_sum_q;
  assign res_overflow = res_ovf_q;
  assign res_id       = res_id_q;
  assign ovf_cnt0     = ovf_cnt0_q;
  assign ovf_cnt1     = ovf_cnt1_q;

endmodule : signed_add_arbiter
